vend_sequencer: RTL and testbench

- Clocked controller that sequences one vending transaction end to end: latches the selected product price, accumulates inserted coins, and dispenses the product when credit covers the price.
- Then pays out change, or a full refund on cancel/timeout, one coin at a time through a handshake to the change-coin dispenser.
- Sits between the product-select switches, the coin acceptor and the product/change actuators.
- Replaces the combinational price/credit bookkeeping with a single synchronous FSM.

---
 rtl/vend_sequencer_if.sv | 27 ++
 rtl/vend_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_vend_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_sequencer_if.sv
// Vending controller I/O bundle: selection switches, coin acceptor, product and change actuators.
// master drives the user/acceptor side, slave is the sequencer.
interface vend_sequencer_if;
  logic       sel_valid;
  logic [3:0] price_msb;
  logic [3:0] price_lsb;
  logic [3:0] coin;
  logic       cancel;
  logic       chg_ack;
  logic       product_out;
  logic [3:0] chg_coin;
  logic       coin_reject;
  logic       sel_error;
  logic       busy;
  logic [3:0] credit_msb;
  logic [3:0] credit_lsb;

  modport master (
    output sel_valid, price_msb, price_lsb, coin, cancel, chg_ack,
    input  product_out, chg_coin, coin_reject, sel_error, busy, credit_msb, credit_lsb
  );

  modport slave (
    input  sel_valid, price_msb, price_lsb, coin, cancel, chg_ack,
    output product_out, chg_coin, coin_reject, sel_error, busy, credit_msb, credit_lsb
  );
endinterface

// File: rtl/vend_sequencer.sv
// One-transaction vending sequencer: price latch, coin accumulation, vend, and
// coin-by-coin change/refund payout. Money is counted in units of 10 sen.
//
// state   | meaning
// IDLE    | waiting for a valid selection, coins are rejected
// COLLECT | accumulating credit against the latched price, timeout running
// VEND    | product_out pulse, change = credit - price
// CHANGE  | paying out remaining change one greedy coin per chg_ack
module vend_sequencer #(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 10
) (
  input logic             i_clk,
  input logic             i_reset,
  vend_sequencer_if.slave if_vend
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_VEND    = 2'd2;
  localparam logic [1:0] ST_CHANGE  = 2'd3;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      r_state;
  logic [6:0]      r_price;
  logic [6:0]      r_credit;
  logic [TO_W-1:0] r_to_cnt;
  logic [3:0]      r_chg_coin;
  logic            r_product_out;
  logic            r_coin_reject;
  logic            r_sel_error;
  logic            r_busy;
  logic [3:0]      r_credit_msb;
  logic [3:0]      r_credit_lsb;

  logic [6:0]      w_coin_val;
  logic            w_coin_one;
  logic            w_coin_multi;
  logic            w_price_ok;
  logic [6:0]      w_price_val;
  logic [6:0]      w_credit_upd;
  logic            w_to_hit;
  logic [3:0]      w_greedy;
  logic [6:0]      w_chg_val;
  logic [6:0]      w_credit_sub;

  logic [1:0]      w_state_nxt;
  logic [6:0]      w_price_nxt;
  logic [6:0]      w_credit_nxt;
  logic [TO_W-1:0] w_to_nxt;
  logic [3:0]      w_chg_nxt;
  logic            w_product_nxt;
  logic            w_reject_nxt;
  logic            w_sel_err_nxt;

  always_comb begin
    w_coin_val = 7'd0;
    case (if_vend.coin)
      4'b0001: w_coin_val = 7'd1;
      4'b0010: w_coin_val = 7'd2;
      4'b0100: w_coin_val = 7'd5;
      4'b1000: w_coin_val = 7'd10;
      default: w_coin_val = 7'd0;
    endcase
  end

  assign w_coin_one   = (w_coin_val != 7'd0);
  assign w_coin_multi = (if_vend.coin != 4'd0) && !w_coin_one;

  assign w_price_ok  = (if_vend.price_msb <= 4'd9) && (if_vend.price_lsb <= 4'd9) &&
                       ((if_vend.price_msb | if_vend.price_lsb) != 4'd0);
  assign w_price_val = 7'(if_vend.price_msb) * 7'd10 + 7'(if_vend.price_lsb);

  // Credit peaks at 98 + 10 = 108, so 7 bits never wrap.
  assign w_credit_upd = w_coin_one ? (r_credit + w_coin_val) : r_credit;
  assign w_to_hit     = (r_to_cnt == TO_LAST);

  always_comb begin
    w_greedy = 4'b0001;
    if (r_credit >= 7'd10)
      w_greedy = 4'b1000;
    else if (r_credit >= 7'd5)
      w_greedy = 4'b0100;
    else if (r_credit >= 7'd2)
      w_greedy = 4'b0010;
  end

  always_comb begin
    w_chg_val = 7'd0;
    case (r_chg_coin)
      4'b0001: w_chg_val = 7'd1;
      4'b0010: w_chg_val = 7'd2;
      4'b0100: w_chg_val = 7'd5;
      4'b1000: w_chg_val = 7'd10;
      default: w_chg_val = 7'd0;
    endcase
  end

  assign w_credit_sub = r_credit - w_chg_val;

  always_comb begin
    w_state_nxt   = r_state;
    w_price_nxt   = r_price;
    w_credit_nxt  = r_credit;
    w_to_nxt      = r_to_cnt;
    w_chg_nxt     = r_chg_coin;
    w_product_nxt = 1'b0;
    w_reject_nxt  = 1'b0;
    w_sel_err_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_reject_nxt = (if_vend.coin != 4'd0);
        if (if_vend.sel_valid) begin
          if (w_price_ok) begin
            w_price_nxt  = w_price_val;
            w_credit_nxt = 7'd0;
            w_to_nxt     = '0;
            w_state_nxt  = ST_COLLECT;
          end else begin
            w_sel_err_nxt = 1'b1;
          end
        end
      end

      ST_COLLECT: begin
        w_reject_nxt = w_coin_multi;
        w_credit_nxt = w_credit_upd;
        // A coin that covers the price wins over a simultaneous cancel.
        if (w_credit_upd >= r_price) begin
          w_state_nxt   = ST_VEND;
          w_product_nxt = 1'b1;
        end else if (if_vend.cancel || (!w_coin_one && w_to_hit)) begin
          w_to_nxt    = '0;
          w_chg_nxt   = 4'd0;
          w_state_nxt = (w_credit_upd == 7'd0) ? ST_IDLE : ST_CHANGE;
        end else begin
          w_to_nxt = w_coin_one ? '0 : (r_to_cnt + TO_W'(1));
        end
      end

      ST_VEND: begin
        w_reject_nxt = (if_vend.coin != 4'd0);
        w_credit_nxt = r_credit - r_price;
        w_to_nxt     = '0;
        w_chg_nxt    = 4'd0;
        w_state_nxt  = (r_credit == r_price) ? ST_IDLE : ST_CHANGE;
      end

      ST_CHANGE: begin
        w_reject_nxt = (if_vend.coin != 4'd0);
        if (r_chg_coin == 4'd0) begin
          w_chg_nxt = w_greedy;
        end else if (if_vend.chg_ack) begin
          w_credit_nxt = w_credit_sub;
          w_chg_nxt    = 4'd0;
          if (w_credit_sub == 7'd0)
            w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_credit_nxt = 7'd0;
        w_chg_nxt    = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_price       <= 7'd0;
      r_credit      <= 7'd0;
      r_to_cnt      <= '0;
      r_chg_coin    <= 4'd0;
      r_product_out <= 1'b0;
      r_coin_reject <= 1'b0;
      r_sel_error   <= 1'b0;
      r_busy        <= 1'b0;
      r_credit_msb  <= 4'd0;
      r_credit_lsb  <= 4'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_price       <= w_price_nxt;
      r_credit      <= w_credit_nxt;
      r_to_cnt      <= w_to_nxt;
      r_chg_coin    <= w_chg_nxt;
      r_product_out <= w_product_nxt;
      r_coin_reject <= w_reject_nxt;
      r_sel_error   <= w_sel_err_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_credit_msb  <= 4'(w_credit_nxt / 7'd10);
      r_credit_lsb  <= 4'(w_credit_nxt % 7'd10);
    end
  end

  assign if_vend.product_out = r_product_out;
  assign if_vend.chg_coin    = r_chg_coin;
  assign if_vend.coin_reject = r_coin_reject;
  assign if_vend.sel_error   = r_sel_error;
  assign if_vend.busy        = r_busy;
  assign if_vend.credit_msb  = r_credit_msb;
  assign if_vend.credit_lsb  = r_credit_lsb;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios plus random transactions checked
// against a transaction-level money model (credit sums, greedy change lists).
module tb_vend_sequencer;
  localparam int TIMEOUT = 20;
  localparam int TO_W    = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vend_sequencer_if vif();

  vend_sequencer #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .if_vend (vif)
  );

  int n_total = 0;
  int n_pass  = 0;
  int stim_q[$];
  int got_q[$];
  int exp_q[$];
  int denoms[4] = '{1, 2, 5, 10};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [3:0] to_hot(input int v);
    case (v)
      1:       return 4'b0001;
      2:       return 4'b0010;
      5:       return 4'b0100;
      10:      return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int hot_val(input logic [3:0] h);
    case (h)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 5;
      4'b1000: return 10;
      default: return -1;
    endcase
  endfunction

  function automatic int disp(input int c);
    return (c / 10) * 16 + (c % 10);
  endfunction

  function automatic int disp_obs();
    return int'({vif.credit_msb, vif.credit_lsb});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vif.sel_valid = 1'b0;
    vif.price_msb = 4'd0;
    vif.price_lsb = 4'd0;
    vif.coin      = 4'd0;
    vif.cancel    = 1'b0;
    vif.chg_ack   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic select(input logic [3:0] m, input logic [3:0] l);
    vif.price_msb = m;
    vif.price_lsb = l;
    vif.sel_valid = 1'b1;
    step();
    vif.sel_valid = 1'b0;
  endtask

  task automatic put_coin(input logic [3:0] h, input bit c);
    vif.coin   = h;
    vif.cancel = c;
    step();
    vif.coin   = 4'd0;
    vif.cancel = 1'b0;
  endtask

  // Expected payout: largest denomination not exceeding what is still owed.
  task automatic greedy(input int amt);
    int rem;
    rem = amt;
    exp_q.delete();
    while (rem > 0) begin
      int d;
      if (rem >= 10)     d = 10;
      else if (rem >= 5) d = 5;
      else if (rem >= 2) d = 2;
      else               d = 1;
      exp_q.push_back(d);
      rem -= d;
    end
  endtask

  task automatic collect(input string tag);
    bit         bad;
    logic [3:0] held;
    int         n_wait;
    bad = 1'b0;
    got_q.delete();
    for (int guard = 0; guard < 500 && vif.busy; guard++) begin
      if (vif.product_out) bad = 1'b1;
      if (vif.chg_coin != 4'd0) begin
        held   = vif.chg_coin;
        n_wait = $urandom_range(0, 2);
        repeat (n_wait) begin
          step();
          if (vif.chg_coin !== held) bad = 1'b1;
        end
        got_q.push_back(hot_val(held));
        vif.chg_ack = 1'b1;
        step();
        vif.chg_ack = 1'b0;
        if (vif.chg_coin !== 4'd0) bad = 1'b1;
      end else begin
        vif.chg_ack = 1'($urandom_range(0, 1));
        step();
        vif.chg_ack = 1'b0;
      end
    end
    check({tag, " busy_end"}, 32'(vif.busy), 0);
    check({tag, " handshake"}, 32'(bad), 0);
    check({tag, " ncoins"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      check($sformatf("%s coin%0d", tag, i), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
    check({tag, " disp_end"}, disp_obs(), 0);
  endtask

  task automatic run_txn(input string tag, input int m, input int l, input bit cancel_last);
    int  price;
    int  credit;
    bit  vended;
    bit  c;
    price  = m * 10 + l;
    credit = 0;
    vended = 1'b0;
    select(4'(m), 4'(l));
    check({tag, " busy_sel"}, 32'(vif.busy), 1);
    check({tag, " disp_sel"}, disp_obs(), 0);
    for (int i = 0; i < stim_q.size(); i++) begin
      c = cancel_last && (i == stim_q.size() - 1);
      put_coin(to_hot(stim_q[i]), c);
      credit += stim_q[i];
      if (credit >= price) begin
        check($sformatf("%s vend@%0d", tag, i), 32'(vif.product_out), 1);
        vended = 1'b1;
        break;
      end else if (c) begin
        check({tag, " novend_cancel"}, 32'(vif.product_out), 0);
        check({tag, " busy_cancel"}, 32'(vif.busy), 1);
        break;
      end else begin
        check($sformatf("%s pend@%0d", tag, i), 32'(vif.product_out), 0);
        check($sformatf("%s disp@%0d", tag, i), disp_obs(), disp(credit));
      end
    end
    if (vended) begin
      step();
      check({tag, " vend_width"}, 32'(vif.product_out), 0);
      greedy(credit - price);
    end else begin
      greedy(credit);
    end
    collect(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_inputs();
    do_reset();

    check("rst product_out", 32'(vif.product_out), 0);
    check("rst chg_coin", 32'(vif.chg_coin), 0);
    check("rst coin_reject", 32'(vif.coin_reject), 0);
    check("rst sel_error", 32'(vif.sel_error), 0);
    check("rst busy", 32'(vif.busy), 0);
    check("rst credit", disp_obs(), 0);

    // 100+100+50+50 against 2.70 leaves 0.30 change
    stim_q = '{10, 10, 5, 5};
    run_txn("t1", 2, 7, 1'b0);

    stim_q = '{2, 1};
    run_txn("t2", 0, 3, 1'b0);

    stim_q = '{5, 2, 1};
    run_txn("t3", 1, 8, 1'b1);

    // covering coin with cancel in the same cycle still vends
    stim_q = '{2, 5};
    run_txn("t3b", 0, 5, 1'b1);

    // timeout refund
    select(4'd1, 4'd2);
    put_coin(to_hot(5), 1'b0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      n++;
      if (vif.chg_coin != 4'd0) break;
    end
    check("to latency", n, TIMEOUT + 1);
    check("to disp", disp_obs(), disp(5));
    greedy(5);
    collect("to");

    // multi-hot coin rejected, then cancel refunds 12
    select(4'd2, 4'd2);
    put_coin(to_hot(10), 1'b0);
    put_coin(to_hot(2), 1'b0);
    put_coin(4'b0101, 1'b0);
    check("mh reject", 32'(vif.coin_reject), 1);
    check("mh disp", disp_obs(), disp(12));
    check("mh novend", 32'(vif.product_out), 0);
    step();
    check("mh reject_width", 32'(vif.coin_reject), 0);
    put_coin(4'd0, 1'b1);
    greedy(12);
    collect("mh");

    // bad selections and coins in IDLE
    select(4'd2, 4'hA);
    check("sel bcd err", 32'(vif.sel_error), 1);
    check("sel bcd busy", 32'(vif.busy), 0);
    step();
    check("sel err width", 32'(vif.sel_error), 0);
    select(4'd0, 4'd0);
    check("sel zero err", 32'(vif.sel_error), 1);
    check("sel zero busy", 32'(vif.busy), 0);
    put_coin(to_hot(1), 1'b0);
    check("idle reject", 32'(vif.coin_reject), 1);
    check("idle busy", 32'(vif.busy), 0);
    check("idle disp", disp_obs(), 0);

    // reset while a 100-sen refund coin is pending
    select(4'd9, 4'd9);
    put_coin(to_hot(10), 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (vif.chg_coin != 4'd0) break;
      step();
    end
    check("mid chg_coin", 32'(vif.chg_coin), 32'h8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid rst chg_coin", 32'(vif.chg_coin), 0);
    check("mid rst busy", 32'(vif.busy), 0);
    check("mid rst product", 32'(vif.product_out), 0);
    check("mid rst reject", 32'(vif.coin_reject), 0);
    check("mid rst sel_error", 32'(vif.sel_error), 0);
    check("mid rst disp", disp_obs(), 0);
    put_coin(to_hot(2), 1'b0);
    check("mid idle reject", 32'(vif.coin_reject), 1);
    stim_q = '{1};
    run_txn("post", 0, 1, 1'b0);

    // random transactions
    for (int t = 0; t < 30; t++) begin
      int price;
      int credit;
      bit canc;
      price  = $urandom_range(1, 99);
      credit = 0;
      canc   = 1'b0;
      stim_q.delete();
      for (int k = 0; k < 200; k++) begin
        int v;
        v = denoms[$urandom_range(0, 3)];
        stim_q.push_back(v);
        credit += v;
        if (credit >= price) break;
        if ($urandom_range(0, 11) == 0) begin
          canc = 1'b1;
          break;
        end
      end
      run_txn($sformatf("r%0d", t), price / 10, price % 10, canc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
